// File: rtl/pipe_reg_skid_pkg.sv
// pipe_pkg: shared definitions for the skid-buffered pipeline register.
// Holds the occupancy-state encodings and the FSM state type. The encoding
// value doubles as the held-beat count exposed on the level output.
package pipe_pkg;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    typedef enum logic [1:0] {
        S_EMPTY = ST_EMPTY,
        S_ONE   = ST_ONE,
        S_FULL  = ST_FULL
    } state_e;

endpackage

// File: rtl/pipe_reg_skid_if.sv
// pipe_reg_skid_if: bundle of handshake, payload, flush and status signals
// around one pipe_reg_skid stage.
//   master modport: the environment side (drives in_valid/in_data/out_ready/flush)
//   slave modport : the pipeline register itself (drives in_ready/out_valid/
//                   out_data/level/stall_cnt)
interface pipe_reg_skid_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       level;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output flush, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, level, stall_cnt
    );

    modport slave (
        input  flush, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, level, stall_cnt
    );
endinterface

// File: rtl/pipe_reg_skid_reg_en_n.sv
// reg_en_n: WIDTH-bit enable register.
// Ports: clk (rising edge), rst (sync, active-low), clr (sync clear to
// RESET_VAL), en (load enable), d (next value), q (held value).
// Priority: rst > clr > en; otherwise the value is held.
module reg_en_n #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_r;

    // Data register with reset/clear to RESET_VAL and load on enable.
    always_ff @(posedge clk) begin
        if (!rst) begin
            q_r <= RESET_VAL;
        end else if (clr) begin
            q_r <= RESET_VAL;
        end else if (en) begin
            q_r <= d;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/pipe_reg_skid.sv
// pipe_reg_skid: pipeline register with valid/ready handshake and a
// two-entry skid buffer (main + skid), synchronous flush and a saturating
// back-pressure counter.
// Ports: clk (rising edge), rst (sync, active-low), bus (slave modport of
// pipe_reg_skid_if: flush, in_valid/in_ready/in_data, out_valid/out_ready/
// out_data, level = held beats, stall_cnt = saturating stalled-cycle count).
// in_ready depends only on registered state, rst and flush, never on
// out_ready, so the ready path is cut at every stage.
module pipe_reg_skid
    import pipe_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
    parameter int               CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    pipe_reg_skid_if.slave   bus
);

    state_e           state_r;
    state_e           state_nxt_s;
    logic             in_ready_s;
    logic             out_valid_s;
    logic             in_fire_s;
    logic             out_fire_s;
    logic             main_en_s;
    logic             skid_en_s;
    logic [WIDTH-1:0] main_d_s;
    logic [WIDTH-1:0] main_q_s;
    logic [WIDTH-1:0] skid_q_s;
    logic [CNT_W-1:0] stall_cnt_r;

    assign in_ready_s  = rst & ~bus.flush & (state_r != S_FULL);
    assign out_valid_s = (state_r != S_EMPTY);
    assign in_fire_s   = bus.in_valid & in_ready_s;
    assign out_fire_s  = out_valid_s & bus.out_ready;

    // Next-state and data-register load selection.
    always_comb begin
        state_nxt_s = state_r;
        main_en_s   = 1'b0;
        skid_en_s   = 1'b0;
        main_d_s    = bus.in_data;
        case (state_r)
            S_EMPTY: begin
                if (in_fire_s) begin
                    main_en_s   = 1'b1;
                    state_nxt_s = S_ONE;
                end else begin
                    state_nxt_s = S_EMPTY;
                end
            end
            S_ONE: begin
                if (in_fire_s && out_fire_s) begin
                    main_en_s   = 1'b1;
                    state_nxt_s = S_ONE;
                end else if (in_fire_s) begin
                    // Downstream stalled: park the new beat behind main.
                    skid_en_s   = 1'b1;
                    state_nxt_s = S_FULL;
                end else if (out_fire_s) begin
                    state_nxt_s = S_EMPTY;
                end else begin
                    state_nxt_s = S_ONE;
                end
            end
            S_FULL: begin
                if (out_fire_s) begin
                    main_en_s   = 1'b1;
                    main_d_s    = skid_q_s;
                    state_nxt_s = S_ONE;
                end else begin
                    state_nxt_s = S_FULL;
                end
            end
            default: begin
                // Encoding 3 is unreachable; recover to a clean empty stage.
                state_nxt_s = S_EMPTY;
            end
        endcase
    end

    // Occupancy state register; flush empties the stage.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= S_EMPTY;
        end else if (bus.flush) begin
            state_r <= S_EMPTY;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Saturating count of cycles where a beat waits on downstream; flush holds it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (bus.flush) begin
            stall_cnt_r <= stall_cnt_r;
        end else if (out_valid_s && !bus.out_ready && (stall_cnt_r != {CNT_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + CNT_W'(1);
        end
    end

    reg_en_n #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_main (
        .clk (clk),
        .rst (rst),
        .clr (bus.flush),
        .en  (main_en_s),
        .d   (main_d_s),
        .q   (main_q_s)
    );

    reg_en_n #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_skid (
        .clk (clk),
        .rst (rst),
        .clr (bus.flush),
        .en  (skid_en_s),
        .d   (bus.in_data),
        .q   (skid_q_s)
    );

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_s;
    assign bus.out_data  = main_q_s;
    assign bus.level     = state_r;
    assign bus.stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_pipe_reg_skid.sv
// tb_pipe_reg_skid: directed self-checking bench for pipe_reg_skid.
// Instance a: WIDTH=32, CNT_W=16. Instance b: WIDTH=8, CNT_W=3 for the
// counter saturation case. Inputs change 1 time unit after a rising edge and
// outputs are sampled there too.
module tb_pipe_reg_skid;

    logic clk;
    logic rst;
    logic rst_b;
    int   tests;
    int   fails;

    pipe_reg_skid_if #(.WIDTH(32), .CNT_W(16)) bus_a ();
    pipe_reg_skid_if #(.WIDTH(8),  .CNT_W(3))  bus_b ();

    pipe_reg_skid #(.WIDTH(32), .RESET_VAL(32'h0), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    pipe_reg_skid #(.WIDTH(8), .RESET_VAL(8'h0), .CNT_W(3)) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (bus_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst   = 1'b0;
        rst_b = 1'b0;
        bus_a.flush     = 1'b0;
        bus_a.in_valid  = 1'b1;
        bus_a.in_data   = 32'hDEADBEEF;
        bus_a.out_ready = 1'b0;
        bus_b.flush     = 1'b0;
        bus_b.in_valid  = 1'b0;
        bus_b.in_data   = 8'h00;
        bus_b.out_ready = 1'b0;

        // 1. reset held two cycles with a beat offered
        tick();
        tick();
        chk("rst_out_valid", 32'(bus_a.out_valid), 32'd0);
        chk("rst_level",     32'(bus_a.level),     32'd0);
        chk("rst_in_ready",  32'(bus_a.in_ready),  32'd0);
        chk("rst_stall",     32'(bus_a.stall_cnt), 32'd0);
        chk("rst_out_data",  bus_a.out_data,       32'h0);
        rst = 1'b1;
        bus_a.in_valid = 1'b0;
        #1;
        chk("rel_in_ready",  32'(bus_a.in_ready),  32'd1);

        // 2. streaming with out_ready high
        bus_a.out_ready = 1'b1;
        bus_a.in_valid  = 1'b1;
        bus_a.in_data   = 32'h1;
        tick();
        chk("str1_data",  bus_a.out_data,       32'h1);
        chk("str1_level", 32'(bus_a.level),     32'd1);
        chk("str1_ready", 32'(bus_a.in_ready),  32'd1);
        bus_a.in_data = 32'h2;
        tick();
        chk("str2_data",  bus_a.out_data,       32'h2);
        chk("str2_level", 32'(bus_a.level),     32'd1);
        chk("str2_ready", 32'(bus_a.in_ready),  32'd1);
        bus_a.in_data = 32'h3;
        tick();
        chk("str3_data",  bus_a.out_data,       32'h3);
        chk("str3_level", 32'(bus_a.level),     32'd1);
        bus_a.in_valid = 1'b0;
        tick();
        chk("str_drain_level", 32'(bus_a.level),     32'd0);
        chk("str_drain_valid", 32'(bus_a.out_valid), 32'd0);
        chk("str_stall",       32'(bus_a.stall_cnt), 32'd0);

        // 3. back-pressure fills the skid buffer
        bus_a.out_ready = 1'b0;
        bus_a.in_valid  = 1'b1;
        bus_a.in_data   = 32'hA;
        tick();
        chk("bp_a_data",  bus_a.out_data,   32'hA);
        chk("bp_a_level", 32'(bus_a.level), 32'd1);
        bus_a.in_data = 32'hB;
        tick();
        chk("bp_full_level", 32'(bus_a.level),     32'd2);
        chk("bp_full_ready", 32'(bus_a.in_ready),  32'd0);
        chk("bp_full_data",  bus_a.out_data,       32'hA);
        chk("bp_stall1",     32'(bus_a.stall_cnt), 32'd1);
        bus_a.in_data = 32'hC;
        tick();
        chk("bp_c_rejected", 32'(bus_a.level),     32'd2);
        chk("bp_hold_data",  bus_a.out_data,       32'hA);
        tick();
        chk("bp_stall3",     32'(bus_a.stall_cnt), 32'd3);
        bus_a.out_ready = 1'b1;
        tick();
        chk("bp_b_data",  bus_a.out_data,   32'hB);
        chk("bp_b_level", 32'(bus_a.level), 32'd1);
        tick();
        chk("bp_c_data",  bus_a.out_data,   32'hC);
        chk("bp_c_level", 32'(bus_a.level), 32'd1);
        bus_a.in_valid = 1'b0;
        tick();
        chk("bp_drain_level", 32'(bus_a.level),     32'd0);
        chk("bp_stall_final", 32'(bus_a.stall_cnt), 32'd3);

        // 4. flush while full
        bus_a.out_ready = 1'b0;
        bus_a.in_valid  = 1'b1;
        bus_a.in_data   = 32'h11;
        tick();
        bus_a.in_data = 32'h22;
        tick();
        bus_a.in_valid = 1'b0;
        tick();
        chk("fl_pre_level", 32'(bus_a.level),     32'd2);
        chk("fl_pre_stall", 32'(bus_a.stall_cnt), 32'd5);
        bus_a.flush    = 1'b1;
        bus_a.in_valid = 1'b1;
        bus_a.in_data  = 32'h99;
        #1;
        chk("fl_in_ready", 32'(bus_a.in_ready), 32'd0);
        tick();
        bus_a.flush    = 1'b0;
        bus_a.in_valid = 1'b0;
        chk("fl_level", 32'(bus_a.level),     32'd0);
        chk("fl_valid", 32'(bus_a.out_valid), 32'd0);
        chk("fl_data",  bus_a.out_data,       32'h0);
        chk("fl_stall", 32'(bus_a.stall_cnt), 32'd5);

        // 5. simultaneous in_fire and out_fire in ONE
        bus_a.in_valid = 1'b1;
        bus_a.in_data  = 32'h44;
        tick();
        chk("sim_first", bus_a.out_data, 32'h44);
        bus_a.out_ready = 1'b1;
        bus_a.in_data   = 32'h55;
        tick();
        chk("sim_data",  bus_a.out_data,       32'h55);
        chk("sim_level", 32'(bus_a.level),     32'd1);
        chk("sim_stall", 32'(bus_a.stall_cnt), 32'd5);
        bus_a.in_valid = 1'b0;
        tick();
        chk("sim_drain", 32'(bus_a.level), 32'd0);

        // 6. 3-bit counter saturation and mid-stall reset
        rst_b = 1'b1;
        bus_b.in_valid = 1'b1;
        bus_b.in_data  = 8'h77;
        tick();
        bus_b.in_valid = 1'b0;
        chk("sat_data", 32'(bus_b.out_data), 32'h77);
        for (int i = 0; i < 5; i++) tick();
        chk("sat_cnt5", 32'(bus_b.stall_cnt), 32'd5);
        for (int i = 0; i < 5; i++) tick();
        chk("sat_cnt10", 32'(bus_b.stall_cnt), 32'd7);
        tick();
        tick();
        chk("sat_hold",  32'(bus_b.stall_cnt), 32'd7);
        chk("sat_level", 32'(bus_b.level),     32'd1);
        rst_b = 1'b0;
        tick();
        rst_b = 1'b1;
        chk("sat_rst_cnt",   32'(bus_b.stall_cnt), 32'd0);
        chk("sat_rst_level", 32'(bus_b.level),     32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
